// File: rtl/fetch_if.sv
// fetch_if: bundles the fetch-stage control, memory and IF/ID signals between fetch_unit and its neighbours.
interface fetch_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] instruction;
    logic [31:0] PC;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        pc_oob;
    logic        misalign_err;
    logic [31:0] fetch_count;
    modport master (
        input  stall, branch_taken, branch_target, jump, jump_index, jr, jr_target, instruction,
        output PC, ifid_instr, ifid_pc_plus4, ifid_valid, pc_oob, misalign_err, fetch_count
    );
    modport slave (
        output stall, branch_taken, branch_target, jump, jump_index, jr, jr_target, instruction,
        input  PC, ifid_instr, ifid_pc_plus4, ifid_valid, pc_oob, misalign_err, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction-fetch stage owning the PC and the IF/ID pipeline register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_SIZE = 256
) (
    input logic     clk,
    input logic     resetN,
    fetch_if.master bus
);
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        redirect;
    always_comb begin
        pc_plus4 = bus.PC + 32'd4;
        redirect = bus.branch_taken | bus.jump | bus.jr;
        target   = bus.branch_taken ? bus.branch_target :
                   bus.jr           ? bus.jr_target :
                                      {pc_plus4[31:28], bus.jump_index, 2'b00};
    end
    assign bus.pc_oob = bus.PC >= 32'(MEM_SIZE);
    // Redirect squashes the wrong-path word and wins over stall; out-of-range fetches become bubbles.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bus.PC            <= RESET_PC;
            bus.ifid_instr    <= '0;
            bus.ifid_pc_plus4 <= '0;
            bus.ifid_valid    <= 1'b0;
            bus.misalign_err  <= 1'b0;
            bus.fetch_count   <= '0;
        end else if (redirect) begin
            bus.PC           <= target;
            bus.ifid_instr   <= '0;
            bus.ifid_valid   <= 1'b0;
            bus.misalign_err <= bus.misalign_err | (target[1:0] != 2'b00);
        end else if (!bus.stall) begin
            bus.PC            <= pc_plus4;
            bus.ifid_instr    <= bus.pc_oob ? 32'd0 : bus.instruction;
            bus.ifid_valid    <= !bus.pc_oob;
            bus.ifid_pc_plus4 <= bus.pc_oob ? bus.ifid_pc_plus4 : pc_plus4;
            bus.fetch_count   <= bus.fetch_count + 32'(!bus.pc_oob);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus random stimulus against a behavioural fetch-stage model.
module tb_fetch_unit;
    localparam logic [31:0] MEM = 32'd256;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int n_checks = 0;
    int n_pass = 0;
    logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
    logic        m_valid, m_err;
    fetch_if bus ();
    fetch_unit #(.RESET_PC(32'h0), .MEM_SIZE(256)) dut (.clk(clk), .resetN(resetN), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B9 + 32'h0123_4567;
    endfunction
    assign bus.instruction = mem_word(bus.PC);
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    endtask
    task automatic check_all();
        check("PC", bus.PC, m_pc);
        check("ifid_instr", bus.ifid_instr, m_instr);
        check("ifid_pc_plus4", bus.ifid_pc_plus4, m_pp4);
        check("ifid_valid", 32'(bus.ifid_valid), 32'(m_valid));
        check("misalign_err", 32'(bus.misalign_err), 32'(m_err));
        check("fetch_count", bus.fetch_count, m_cnt);
        check("pc_oob", 32'(bus.pc_oob), 32'(m_pc >= MEM));
    endtask
    task automatic idle();
        bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
        bus.jump = 0; bus.jump_index = 0; bus.jr = 0; bus.jr_target = 0;
    endtask
    // Asserted a couple of ns after a falling edge so the check lands before any rising edge.
    task automatic do_reset();
        idle();
        #2 resetN = 1'b0;
        #1;
        m_pc = 0; m_instr = 0; m_pp4 = 0; m_cnt = 0; m_valid = 0; m_err = 0;
        check_all();
        @(negedge clk);
        resetN = 1'b1;
    endtask
    task automatic step(input logic s, input logic b, input logic [31:0] bt, input logic j,
                        input logic [25:0] ji, input logic r, input logic [31:0] rt);
        logic [31:0] p4, tgt;
        bus.stall = s; bus.branch_taken = b; bus.branch_target = bt;
        bus.jump = j; bus.jump_index = ji; bus.jr = r; bus.jr_target = rt;
        #1;
        check("pc_oob_pre", 32'(bus.pc_oob), 32'(m_pc >= MEM));
        p4 = m_pc + 32'd4;
        tgt = b ? bt : r ? rt : {p4[31:28], ji, 2'b00};
        if (b || j || r) begin
            m_valid = 0; m_instr = 0; m_pc = tgt;
            if (tgt[1:0] != 2'b00) m_err = 1;
        end else if (!s) begin
            if (m_pc >= MEM) begin
                m_valid = 0; m_instr = 0;
            end else begin
                m_instr = mem_word(m_pc); m_pp4 = p4; m_valid = 1; m_cnt = m_cnt + 1;
            end
            m_pc = p4;
        end
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask
    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        idle();
        @(negedge clk);
        do_reset();
        seq(4);
        do_reset();
        seq(2);
        step(0, 0, 0, 1, 26'd9, 0, 0);
        check("jump_pc", bus.PC, 32'h24);
        seq(2);
        do_reset();
        seq(4);
        step(0, 1, 32'h40, 1, 26'd3, 1, 32'h80);
        check("prio_pc", bus.PC, 32'h40);
        do_reset();
        seq(5);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
        check("stall_pc", bus.PC, 32'd20);
        seq(1);
        check("stall_release_pc", bus.PC, 32'd24);
        do_reset();
        seq(63);
        check("pc_252", bus.PC, 32'd252);
        seq(3);
        step(0, 0, 0, 0, 0, 1, 32'h6);
        check("misalign_set", 32'(bus.misalign_err), 32'd1);
        seq(3);
        step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        seq(2);
        check("wrap_pc", bus.PC, 32'd4);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 2) do_reset();
            else step($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10,
                      32'($urandom_range(0, 300)) & ($urandom_range(0, 9) == 0 ? 32'hFFFF_FFFF : 32'hFFFF_FFFC),
                      $urandom_range(0, 99) < 8, 26'($urandom_range(0, 80)),
                      $urandom_range(0, 99) < 8,
                      32'($urandom_range(0, 300)) & ($urandom_range(0, 9) == 0 ? 32'hFFFF_FFFF : 32'hFFFF_FFFC));
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
